// File: rtl/uc_pkg.sv
// Shared encodings for the uc_seq sequencing control unit: opcodes, ALU op, FSM states.
package uc_pkg;
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  // LI matches on Opcode[5:2] only; the low two bits are don't-care.
  localparam logic [5:0] OP_LI   = 6'b100000;
  localparam logic [5:0] OP_J    = 6'b100100;
  localparam logic [5:0] OP_JZ   = 6'b100101;
  localparam logic [5:0] OP_JNZ  = 6'b100110;
  localparam logic [5:0] OP_WAIT = 6'b100111;
  localparam logic [5:0] OP_HALT = 6'b101000;
  localparam logic [5:0] OP_NOP  = 6'b101001;

  localparam logic [2:0] ALUOP_PASS_B = 3'b000;

  function automatic logic is_li(input logic [5:0] op);
    return op[5:2] == OP_LI[5:2];
  endfunction
endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter for the WAIT instruction; stops at zero so it never wraps.
module wait_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: decodes Opcode/zero into datapath controls, with boot delay,
// multi-cycle WAIT, HALT and a sticky illegal-opcode flag.
module uc_seq
  import uc_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int WAIT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        Opcode,
  input  logic              zero,
  input  logic [WAIT_W-1:0] wait_len,
  output logic              s_inc,
  output logic              s_inm,
  output logic              we,
  output logic              wez,
  output logic [2:0]        ALUOp,
  output logic              pc_en,
  output logic              halted,
  output logic              illegal
);
  localparam int BOOT_LEN = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
  localparam int BW       = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_LEN - 1);

  state_e      r_state;
  logic [BW-1:0] r_boot_cnt;
  logic        r_halted;
  logic        r_illegal;
  logic        w_cnt_zero;
  logic        w_wait_go;
  logic        w_bad_op;

  // WAIT with a zero operand is a NOP and never enters the WAIT state.
  assign w_wait_go = (r_state == ST_RUN) && (Opcode == OP_WAIT) && (wait_len != '0);

  wait_counter #(.W(WAIT_W)) u_wait_cnt (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_wait_go),
    .i_load_val (wait_len - WAIT_W'(1)),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    pc_en    = 1'b0;
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    we       = 1'b0;
    wez      = 1'b0;
    ALUOp    = ALUOP_PASS_B;
    w_bad_op = 1'b0;
    case (r_state)
      ST_RUN: begin
        pc_en = 1'b1;
        if (!Opcode[5]) begin
          ALUOp = Opcode[4:2];
          we    = 1'b1;
          wez   = 1'b1;
        end else if (is_li(Opcode)) begin
          s_inm = 1'b1;
          we    = 1'b1;
        end else begin
          case (Opcode)
            OP_J:    s_inc = 1'b0;
            OP_JZ:   s_inc = ~zero;
            OP_JNZ:  s_inc = zero;
            OP_WAIT: pc_en = (wait_len == '0);
            OP_HALT: pc_en = 1'b0;
            OP_NOP:  ;
            default: w_bad_op = 1'b1;
          endcase
        end
      end
      ST_WAIT: pc_en = w_cnt_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= '0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == BOOT_LAST) r_state <= ST_RUN;
          else                         r_boot_cnt <= r_boot_cnt + BW'(1);
        end
        ST_RUN: begin
          if (w_bad_op) r_illegal <= 1'b1;
          if (w_wait_go) r_state <= ST_WAIT;
          else if (Opcode == OP_HALT) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_WAIT: if (w_cnt_zero) r_state <= ST_RUN;
        default: ;
      endcase
    end
  end

  assign halted  = r_halted;
  assign illegal = r_illegal;
endmodule
